// File: rtl/axi_rt_cfg_sequencer.sv
// AXI4-Lite master that snapshots per-manager period/budget/enable values on start
// and writes them into the RT unit's register file, strictly one write at a time.

module axi_rt_cfg_sequencer #(
  parameter int unsigned RtNumManagers      = 2,
  parameter int unsigned RtPeriodWidth      = 32,
  parameter int unsigned RtBudgetWidth      = 32,
  parameter int unsigned RtAxiLiteAddrWidth = 32,
  parameter int unsigned RtAxiLiteDataWidth = 32,
  parameter logic [RtAxiLiteAddrWidth-1:0] CfgBaseAddr = 32'h0,
  parameter logic [RtAxiLiteAddrWidth-1:0] MgrStride   = 32'h20,
  parameter logic [RtAxiLiteAddrWidth-1:0] PeriodOff   = 32'h0,
  parameter logic [RtAxiLiteAddrWidth-1:0] BudgetOff   = 32'h4,
  parameter logic [RtAxiLiteAddrWidth-1:0] EnableOff   = 32'h8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    start_i,
  input  logic [RtNumManagers*RtPeriodWidth-1:0]  period_i,
  input  logic [RtNumManagers*RtBudgetWidth-1:0]  budget_i,
  input  logic [RtNumManagers-1:0]                enable_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    error_o,
  output logic [RtAxiLiteAddrWidth-1:0]           m_axi_lite_awaddr_o,
  output logic [2:0]                              m_axi_lite_awprot_o,
  output logic                                    m_axi_lite_awvalid_o,
  input  logic                                    m_axi_lite_awready_i,
  output logic [RtAxiLiteDataWidth-1:0]           m_axi_lite_wdata_o,
  output logic [RtAxiLiteDataWidth/8-1:0]         m_axi_lite_wstrb_o,
  output logic                                    m_axi_lite_wvalid_o,
  input  logic                                    m_axi_lite_wready_i,
  input  logic [1:0]                              m_axi_lite_bresp_i,
  input  logic                                    m_axi_lite_bvalid_i,
  output logic                                    m_axi_lite_bready_o
);

  localparam int unsigned MgrIdxWidth = (RtNumManagers > 1) ? $clog2(RtNumManagers) : 1;
  localparam int unsigned StrbWidth   = RtAxiLiteDataWidth / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                                state_r, state_s;
  logic [RtNumManagers*RtPeriodWidth-1:0] period_snap_r, period_snap_s;
  logic [RtNumManagers*RtBudgetWidth-1:0] budget_snap_r, budget_snap_s;
  logic [RtNumManagers-1:0]               enable_snap_r, enable_snap_s;
  logic [MgrIdxWidth-1:0]                 mgr_r, mgr_s, nxt_mgr_s;
  logic [1:0]                             fld_r, fld_s, nxt_fld_s;
  logic                                   aw_done_r, aw_done_s;
  logic                                   w_done_r, w_done_s;
  logic                                   awvalid_r, awvalid_s;
  logic                                   wvalid_r, wvalid_s;
  logic                                   bready_r, bready_s;
  logic [RtAxiLiteAddrWidth-1:0]          awaddr_r, awaddr_s;
  logic [RtAxiLiteDataWidth-1:0]          wdata_r, wdata_s;
  logic                                   busy_r, busy_s;
  logic                                   done_r, done_s;
  logic                                   error_r, error_s;
  logic                                   aw_hs_s, w_hs_s, last_write_s;

  // Address arithmetic wraps in the AXI address width.
  function automatic logic [RtAxiLiteAddrWidth-1:0] calc_addr(
    input logic [MgrIdxWidth-1:0] mgr,
    input logic [1:0]             fld
  );
    logic [RtAxiLiteAddrWidth-1:0] off;
    logic [RtAxiLiteAddrWidth-1:0] mgr_ext;
    case (fld)
      2'd0:    off = PeriodOff;
      2'd1:    off = BudgetOff;
      2'd2:    off = EnableOff;
      default: off = PeriodOff;
    endcase
    mgr_ext = RtAxiLiteAddrWidth'(mgr);
    return CfgBaseAddr + mgr_ext * MgrStride + off;
  endfunction

  function automatic logic [RtAxiLiteDataWidth-1:0] calc_data(
    input logic [RtNumManagers*RtPeriodWidth-1:0] per,
    input logic [RtNumManagers*RtBudgetWidth-1:0] bud,
    input logic [RtNumManagers-1:0]               en,
    input logic [MgrIdxWidth-1:0]                 mgr,
    input logic [1:0]                             fld
  );
    logic [RtAxiLiteDataWidth-1:0] data;
    case (fld)
      2'd0:    data = RtAxiLiteDataWidth'(per[mgr*RtPeriodWidth +: RtPeriodWidth]);
      2'd1:    data = RtAxiLiteDataWidth'(bud[mgr*RtBudgetWidth +: RtBudgetWidth]);
      2'd2:    data = RtAxiLiteDataWidth'(en[mgr]);
      default: data = '0;
    endcase
    return data;
  endfunction

  assign aw_hs_s      = awvalid_r & m_axi_lite_awready_i;
  assign w_hs_s       = wvalid_r & m_axi_lite_wready_i;
  assign last_write_s = (mgr_r == MgrIdxWidth'(RtNumManagers - 1)) && (fld_r == 2'd2);
  assign nxt_fld_s    = (fld_r == 2'd2) ? 2'd0 : fld_r + 2'd1;
  assign nxt_mgr_s    = (fld_r == 2'd2) ? mgr_r + MgrIdxWidth'(1) : mgr_r;

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_s       = state_r;
    period_snap_s = period_snap_r;
    budget_snap_s = budget_snap_r;
    enable_snap_s = enable_snap_r;
    mgr_s         = mgr_r;
    fld_s         = fld_r;
    aw_done_s     = aw_done_r;
    w_done_s      = w_done_r;
    awvalid_s     = awvalid_r;
    wvalid_s      = wvalid_r;
    bready_s      = bready_r;
    awaddr_s      = awaddr_r;
    wdata_s       = wdata_r;
    busy_s        = busy_r;
    done_s        = 1'b0;
    error_s       = error_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          period_snap_s = period_i;
          budget_snap_s = budget_i;
          enable_snap_s = enable_i;
          mgr_s         = '0;
          fld_s         = 2'd0;
          error_s       = 1'b0;
          busy_s        = 1'b1;
          aw_done_s     = 1'b0;
          w_done_s      = 1'b0;
          awvalid_s     = 1'b1;
          wvalid_s      = 1'b1;
          // Snapshot is not registered yet, so the first beat comes from the inputs.
          awaddr_s      = calc_addr('0, 2'd0);
          wdata_s       = calc_data(period_i, budget_i, enable_i, '0, 2'd0);
          state_s       = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (aw_hs_s) begin
          awvalid_s = 1'b0;
          aw_done_s = 1'b1;
        end else begin
          aw_done_s = aw_done_r;
        end
        if (w_hs_s) begin
          wvalid_s = 1'b0;
          w_done_s = 1'b1;
        end else begin
          w_done_s = w_done_r;
        end
        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
          bready_s = 1'b1;
          state_s  = RESP;
        end else begin
          state_s = ISSUE;
        end
      end
      RESP: begin
        if (m_axi_lite_bvalid_i) begin
          bready_s = 1'b0;
          if (m_axi_lite_bresp_i != 2'b00) begin
            error_s = 1'b1;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = DONE;
          end else if (last_write_s) begin
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = DONE;
          end else begin
            mgr_s     = nxt_mgr_s;
            fld_s     = nxt_fld_s;
            aw_done_s = 1'b0;
            w_done_s  = 1'b0;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
            awaddr_s  = calc_addr(nxt_mgr_s, nxt_fld_s);
            wdata_s   = calc_data(period_snap_r, budget_snap_r, enable_snap_r,
                                  nxt_mgr_s, nxt_fld_s);
            state_s   = ISSUE;
          end
        end else begin
          state_s = RESP;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        bready_s  = 1'b0;
        busy_s    = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  // State, snapshot and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= IDLE;
      period_snap_r <= '0;
      budget_snap_r <= '0;
      enable_snap_r <= '0;
      mgr_r         <= '0;
      fld_r         <= 2'd0;
      aw_done_r     <= 1'b0;
      w_done_r      <= 1'b0;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      awaddr_r      <= '0;
      wdata_r       <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      period_snap_r <= period_snap_s;
      budget_snap_r <= budget_snap_s;
      enable_snap_r <= enable_snap_s;
      mgr_r         <= mgr_s;
      fld_r         <= fld_s;
      aw_done_r     <= aw_done_s;
      w_done_r      <= w_done_s;
      awvalid_r     <= awvalid_s;
      wvalid_r      <= wvalid_s;
      bready_r      <= bready_s;
      awaddr_r      <= awaddr_s;
      wdata_r       <= wdata_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      error_r       <= error_s;
    end
  end

  assign busy_o               = busy_r;
  assign done_o               = done_r;
  assign error_o              = error_r;
  assign m_axi_lite_awaddr_o  = awaddr_r;
  assign m_axi_lite_awprot_o  = 3'b000;
  assign m_axi_lite_awvalid_o = awvalid_r;
  assign m_axi_lite_wdata_o   = wdata_r;
  assign m_axi_lite_wstrb_o   = {StrbWidth{1'b1}};
  assign m_axi_lite_wvalid_o  = wvalid_r;
  assign m_axi_lite_bready_o  = bready_r;

endmodule

// File: doc/axi_rt_cfg_sequencer.md
Name: axi_rt_cfg_sequencer

Overview:
- AXI4-Lite master that programs the per-manager period, budget and enable registers of the AXI RT unit through its AXI-Lite configuration port, with no CPU involvement.
- On a start pulse, snapshots a configuration vector and issues 3*RtNumManagers single-beat writes strictly in order.
- Reports completion or a slave error.
- Sits between boot/reset logic (or a test harness) and the RT unit's `s_axi_lite_rt_*` port.

Parameters:
- RtNumManagers, 2, number of managers to configure
- RtPeriodWidth, 32, width of each period value (≤ RtAxiLiteDataWidth)
- RtBudgetWidth, 32, width of each budget value (≤ RtAxiLiteDataWidth)
- RtAxiLiteAddrWidth, 32, AXI-Lite address width
- RtAxiLiteDataWidth, 32, AXI-Lite data width
- CfgBaseAddr, 32'h0, base address of the RT register file
- MgrStride, 32'h20, address stride between managers
- PeriodOff, 32'h0, period register offset within a manager block
- BudgetOff, 32'h4, budget register offset
- EnableOff, 32'h8, enable register offset

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous active-low
- start_i  in  1  start pulse
- period_i  in  RtNumManagers*RtPeriodWidth  periods; manager m at slice [m*RtPeriodWidth +: RtPeriodWidth]
- budget_i  in  RtNumManagers*RtBudgetWidth  budgets; same slicing rule
- enable_i  in  RtNumManagers  per-manager enable
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle completion pulse
- error_o  out  1  sticky: last sequence saw a non-OKAY response
- m_axi_lite_awaddr_o  out  RtAxiLiteAddrWidth  write address
- m_axi_lite_awprot_o  out  3  constant 3'b000
- m_axi_lite_awvalid_o  out  1
- m_axi_lite_awready_i  in  1
- m_axi_lite_wdata_o  out  RtAxiLiteDataWidth  write data
- m_axi_lite_wstrb_o  out  RtAxiLiteDataWidth/8  all ones
- m_axi_lite_wvalid_o  out  1
- m_axi_lite_wready_i  in  1
- m_axi_lite_bresp_i  in  2
- m_axi_lite_bvalid_i  in  1
- m_axi_lite_bready_o  out  1

Behaviour:
- Reset values (all outputs): busy_o=0, done_o=0, error_o=0, awvalid=0, wvalid=0, bready=0, awaddr=0, wdata=0.
  - Reset takes effect asynchronously, including mid-sequence.
  - In-flight AXI transactions are abandoned; the slave is reset together with this block.
- FSM states: IDLE, ISSUE, RESP, DONE.
- IDLE:
  - start_i=1 snapshots period_i, budget_i and enable_i into registers.
  - Clears the manager counter m and the field counter f (0=period, 1=budget, 2=enable).
  - Clears error_o.
  - Next state: ISSUE. busy_o=1 from the following cycle.
- start_i outside IDLE is ignored; the snapshot is not updated.
- ISSUE:
  - awvalid and wvalid are asserted together, driven from registers.
  - awaddr = CfgBaseAddr + m*MgrStride + {PeriodOff|BudgetOff|EnableOff}[f].
  - wdata is the snapshot value, zero-extended; enable writes {0…, enable[m]}.
  - Each channel deasserts its valid in the cycle after its own handshake. AW and W may complete in either order or in the same cycle.
  - awaddr and wdata stay stable while the corresponding valid is high.
  - Leave ISSUE once both handshakes are done → RESP.
- RESP:
  - bready=1.
  - On bvalid, if bresp≠2'b00: set error_o and go to DONE (abort; no further writes).
  - Otherwise advance f. When f wraps from 2, advance m.
  - After the last write (m=RtNumManagers-1, f=2) → DONE; else → ISSUE.
- DONE: done_o=1 for exactly one cycle, busy_o=0 in the same cycle, → IDLE.
- error_o holds until the next accepted start_i.
- Latency with an always-ready, zero-wait slave:
  - start_i at cycle 0.
  - Write k has its AW/W handshake at cycle 2k+1 and its B handshake at 2k+2.
  - done_o fires at cycle 6*RtNumManagers+1.
- Widths: MgrStride*m is computed in RtAxiLiteAddrWidth bits, wrapping modulo 2^RtAxiLiteAddrWidth.
- Ordering and read channel:
  - Only one write is outstanding at any time; no AW for write k+1 is issued before B of write k.
  - The read channel is not used and is not part of this block.

Test Plan:
1. Zero-wait slave, RtNumManagers=2, period={200,100}, budget={20,10}, enable=2'b10, start at cycle 0 → AW sequence 0x0,0x4,0x8,0x20,0x24,0x28 with wdata 100,10,0,200,20,1; done_o at cycle 13; error_o=0.
2. Slave holds awready low 3 cycles while wready=1 immediately → wvalid drops after its handshake; awaddr stays stable; one write completes; no second AW before its B.
3. Slave returns bresp=2'b10 on the 2nd write → error_o=1; done_o pulses one cycle later; no 3rd AW; the next start_i clears error_o.
4. start_i re-pulsed mid-sequence with changed period_i → ignored; data written equals the first snapshot.
5. rst_ni asserted during RESP → all outputs reach their reset values immediately; a new start_i after release runs the full sequence from m=0, f=0.
6. Random AW/W/B ready-valid delays (0–5 cycles), 200 sequences → scoreboard matches the address/data order; exactly one done_o per accepted start_i.
